regwrite_fwd_pipe: RTL and testbench

Parametrised register-write tracking and forwarding pipeline for the MIPS core.
- Accepts the E-stage write triple (enable, address, data) and carries it through DEPTH post-E stages, the last of which is W.
- Resolves NRD operand lookups against all in-flight writes, youngest first.
- Reports a pending hit when the producing load has not yet returned data, so hazard logic can stall.
- Drives the register-file write port from the final stage.

---
 rtl/regwrite_fwd_pipe.sv | 100 ++++++++++
 tb/tb_regwrite_fwd_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_fwd_pipe.sv
// Register-write tracking pipeline: carries E-stage write triples to W, forwards
// the youngest in-flight value to each lookup port, and flags loads still waiting for data.
module regwrite_fwd_pipe #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int DEPTH    = 2,
   parameter int NRD      = 2,
   parameter int LD_STAGE = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              e_we,
   input  logic [AW-1:0]     e_addr,
   input  logic [DW-1:0]     e_data,
   input  logic              e_late,
   input  logic [DW-1:0]     ld_data,
   input  logic [NRD*AW-1:0] rd_addr,
   input  logic [NRD*DW-1:0] rf_rdata,
   output logic [NRD*DW-1:0] fwd_data,
   output logic [NRD-1:0]    fwd_hit,
   output logic [NRD-1:0]    fwd_pending,
   output logic              wb_we,
   output logic [AW-1:0]     wb_addr,
   output logic [DW-1:0]     wb_data
);

   // Registered stages 1..DEPTH (stage DEPTH is W).
   logic          stgValid [1:DEPTH];
   logic [AW-1:0] stgAddr  [1:DEPTH];
   logic [DW-1:0] stgData  [1:DEPTH];
   logic          stgRdy   [1:DEPTH];

   // Effective view of stages 0..DEPTH, with load data substituted at LD_STAGE.
   logic          effValid [0:DEPTH];
   logic [AW-1:0] effAddr  [0:DEPTH];
   logic [DW-1:0] effData  [0:DEPTH];
   logic          effRdy   [0:DEPTH];

   always_comb begin
      effValid[0] = e_we & ~flush & (e_addr != '0);
      effAddr[0]  = e_addr;
      effData[0]  = e_data;
      effRdy[0]   = ~e_late;
      for (int i = 1; i <= DEPTH; i++) begin
         effValid[i] = stgValid[i];
         effAddr[i]  = stgAddr[i];
         if (i == LD_STAGE && stgValid[i] && !stgRdy[i]) begin
            effData[i] = ld_data;
            effRdy[i]  = 1'b1;
         end else begin
            effData[i] = stgData[i];
            effRdy[i]  = stgRdy[i];
         end
      end
   end

   // stall freezes stages 1..DEPTH; the stage-0 entry is simply not captured,
   // so flush never has to reach into the registered stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i <= DEPTH; i++) begin
            stgValid[i] <= 1'b0;
            stgAddr[i]  <= '0;
            stgData[i]  <= '0;
            stgRdy[i]   <= 1'b1;
         end
      end else if (!stall) begin
         for (int i = 1; i <= DEPTH; i++) begin
            stgValid[i] <= effValid[i-1];
            stgAddr[i]  <= effAddr[i-1];
            stgData[i]  <= effData[i-1];
            stgRdy[i]   <= effRdy[i-1];
         end
      end
   end

   // Oldest-to-youngest scan so the youngest match is the last one written.
   always_comb begin
      fwd_data    = rf_rdata;
      fwd_hit     = '0;
      fwd_pending = '0;
      for (int k = 0; k < NRD; k++) begin
         for (int i = DEPTH; i >= 0; i--) begin
            if (effValid[i] && (rd_addr[k*AW +: AW] != '0) &&
                (effAddr[i] == rd_addr[k*AW +: AW])) begin
               fwd_hit[k]            = 1'b1;
               fwd_pending[k]        = ~effRdy[i];
               fwd_data[k*DW +: DW]  = effData[i];
            end
         end
      end
   end

   assign wb_we   = effValid[DEPTH];
   assign wb_addr = effAddr[DEPTH];
   assign wb_data = effData[DEPTH];

endmodule

// File: tb/tb_regwrite_fwd_pipe.sv
// Bench for regwrite_fwd_pipe: directed scenarios plus a randomized run compared
// against a queue model of the in-flight writes.
module tb_regwrite_fwd_pipe;
   localparam int DW = 32, AW = 5, DEPTH = 2, NRD = 2, LD_STAGE = 2;

   logic              clk = 1'b0;
   logic              rst_n, stall, flush, e_we, e_late;
   logic [AW-1:0]     e_addr;
   logic [DW-1:0]     e_data, ld_data;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rf_rdata;
   logic [NRD*DW-1:0] fwd_data;
   logic [NRD-1:0]    fwd_hit, fwd_pending;
   logic              wb_we;
   logic [AW-1:0]     wb_addr;
   logic [DW-1:0]     wb_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          v;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          r;
   } ent_t;

   // inflight[0] is stage 1, inflight[DEPTH-1] is W.
   ent_t inflight[$];

   regwrite_fwd_pipe #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .LD_STAGE(LD_STAGE)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .e_we(e_we),
      .e_addr(e_addr), .e_data(e_data), .e_late(e_late), .ld_data(ld_data),
      .rd_addr(rd_addr), .rf_rdata(rf_rdata), .fwd_data(fwd_data),
      .fwd_hit(fwd_hit), .fwd_pending(fwd_pending), .wb_we(wb_we),
      .wb_addr(wb_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   function automatic ent_t model_stage(int s);
      ent_t e;
      if (s == 0) begin
         e.v = e_we && !flush && (e_addr != 0);
         e.a = e_addr;
         e.d = e_data;
         e.r = !e_late;
      end else begin
         e = inflight[s-1];
         if (s == LD_STAGE && e.v && !e.r) begin
            e.d = ld_data;
            e.r = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic model_reset();
      ent_t e;
      e.v = 1'b0; e.a = '0; e.d = '0; e.r = 1'b1;
      inflight.delete();
      for (int s = 0; s < DEPTH; s++) inflight.push_back(e);
   endtask

   task automatic model_advance();
      ent_t n;
      if (stall) return;
      n = model_stage(0);
      inflight[LD_STAGE-1] = model_stage(LD_STAGE);
      inflight.push_front(n);
      void'(inflight.pop_back());
   endtask

   task automatic cycle();
      @(posedge clk);
      model_advance();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      stall = 0; flush = 0; e_we = 0; e_late = 0; e_addr = '0; e_data = '0;
      ld_data = '0; rd_addr = '0; rf_rdata = '0;
   endtask

   task automatic drain();
      idle_inputs();
      for (int i = 0; i < DEPTH + 1; i++) cycle();
   endtask

   task automatic test_reset();
      idle_inputs();
      rf_rdata = {$urandom(), $urandom()};
      rd_addr = {AW'(3), AW'(2)};
      #1;
      checks++; if (wb_we !== 1'b0 || wb_addr !== '0 || wb_data !== '0) begin
         errors++; $display("FAIL reset_wb: we=%0b addr=%0d data=%h want 0/0/0", wb_we, wb_addr, wb_data);
      end
      checks++; if (fwd_hit !== '0 || fwd_pending !== '0 || fwd_data !== rf_rdata) begin
         errors++; $display("FAIL reset_fwd: hit=%b pend=%b data=%h want 00/00/%h", fwd_hit, fwd_pending, fwd_data, rf_rdata);
      end
      @(negedge clk); rst_n = 1'b1; model_reset();
      for (int i = 1; i <= 3; i++) begin
         e_we = 1; e_addr = AW'(i); e_data = DW'(32'h100 + i);
         cycle();
      end
      e_we = 0;
      #1;
      checks++; if (fwd_hit !== 2'b11 || wb_we !== 1'b1) begin
         errors++; $display("FAIL preload: hit=%b we=%b want 11/1", fwd_hit, wb_we);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (wb_we !== 1'b0 || fwd_hit !== 2'b00) begin
         errors++; $display("FAIL async_reset: we=%b hit=%b want 0/00", wb_we, fwd_hit);
      end
      @(negedge clk); rst_n = 1'b1; model_reset();
      #1;
      checks++; if (wb_we !== 1'b0 || fwd_hit !== 2'b00 || fwd_data !== rf_rdata) begin
         errors++; $display("FAIL post_release: we=%b hit=%b want 0/00", wb_we, fwd_hit);
      end
      cycle();
      checks++; if (wb_we !== 1'b0) begin
         errors++; $display("FAIL post_release_cycle: we=%b want 0", wb_we);
      end
   endtask

   task automatic test_back_to_back();
      drain();
      rd_addr = {AW'(0), AW'(8)};
      e_we = 1; e_addr = 8; e_data = 32'h11;
      cycle();
      e_data = 32'h22;
      #1;
      checks++; if (fwd_hit[0] !== 1'b1 || fwd_data[DW-1:0] !== 32'h22) begin
         errors++; $display("FAIL b2b_fwd: hit=%b data=%h want 1/22", fwd_hit[0], fwd_data[DW-1:0]);
      end
      cycle();
      e_we = 0;
      #1;
      checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd8 || wb_data !== 32'h11) begin
         errors++; $display("FAIL b2b_wb1: we=%b addr=%0d data=%h want 1/8/11", wb_we, wb_addr, wb_data);
      end
      cycle();
      checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd8 || wb_data !== 32'h22) begin
         errors++; $display("FAIL b2b_wb2: we=%b addr=%0d data=%h want 1/8/22", wb_we, wb_addr, wb_data);
      end
   endtask

   task automatic test_load_use();
      drain();
      rd_addr = {AW'(0), AW'(4)};
      e_we = 1; e_addr = 4; e_late = 1; e_data = 32'h5555;
      #1;
      checks++; if (fwd_hit[0] !== 1'b1 || fwd_pending[0] !== 1'b1) begin
         errors++; $display("FAIL load_s0: hit=%b pend=%b want 1/1", fwd_hit[0], fwd_pending[0]);
      end
      cycle();
      e_we = 0; e_late = 0;
      #1;
      checks++; if (fwd_hit[0] !== 1'b1 || fwd_pending[0] !== 1'b1) begin
         errors++; $display("FAIL load_s1: hit=%b pend=%b want 1/1", fwd_hit[0], fwd_pending[0]);
      end
      cycle();
      ld_data = 32'hDEAD;
      #1;
      checks++; if (fwd_hit[0] !== 1'b1 || fwd_pending[0] !== 1'b0 || fwd_data[DW-1:0] !== 32'hDEAD) begin
         errors++; $display("FAIL load_s2: hit=%b pend=%b data=%h want 1/0/dead", fwd_hit[0], fwd_pending[0], fwd_data[DW-1:0]);
      end
      checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd4 || wb_data !== 32'hDEAD) begin
         errors++; $display("FAIL load_wb: we=%b addr=%0d data=%h want 1/4/dead", wb_we, wb_addr, wb_data);
      end
   endtask

   task automatic test_flush();
      drain();
      rd_addr = {AW'(0), AW'(5)};
      e_we = 1; e_addr = 5; e_data = 32'h55; flush = 1;
      #1;
      checks++; if (fwd_hit[0] !== 1'b0) begin
         errors++; $display("FAIL flush_hit: hit=%b want 0", fwd_hit[0]);
      end
      cycle();
      e_we = 0; flush = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         #1;
         checks++; if (wb_we === 1'b1 && wb_addr === 5'd5) begin
            errors++; $display("FAIL flush_wb: we=%b addr=%0d want no write to 5", wb_we, wb_addr);
         end
         cycle();
      end
   endtask

   task automatic test_zero_and_stall();
      logic [DW-1:0] held;
      drain();
      rd_addr = '0;
      e_we = 1; e_addr = 0; e_data = 32'h99;
      #1;
      checks++; if (fwd_hit !== 2'b00) begin
         errors++; $display("FAIL zero_hit: hit=%b want 00", fwd_hit);
      end
      cycle();
      e_addr = 6; e_data = 32'h66;
      #1;
      checks++; if (wb_we !== 1'b0) begin
         errors++; $display("FAIL zero_wb: we=%b want 0", wb_we);
      end
      cycle();
      e_we = 0;
      cycle();
      held = wb_data;
      stall = 1; e_we = 1; e_addr = 7; e_data = 32'h77;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd6 || wb_data !== 32'h66) begin
            errors++; $display("FAIL stall_hold: we=%b addr=%0d data=%h want 1/6/66", wb_we, wb_addr, wb_data);
         end
      end
      stall = 0; e_we = 0;
      cycle();
      checks++; if (wb_we !== 1'b0) begin
         errors++; $display("FAIL stall_resume: we=%b addr=%0d want 0 (held %h)", wb_we, wb_addr, held);
      end
   endtask

   task automatic test_multiport();
      drain();
      rd_addr = {AW'(9), AW'(3)};
      rf_rdata = {32'hAB, 32'h55};
      e_we = 1; e_addr = 3; e_data = 32'h7;
      cycle();
      e_we = 0;
      #1;
      checks++; if (fwd_hit[1] !== 1'b0 || fwd_data[DW +: DW] !== 32'hAB) begin
         errors++; $display("FAIL mp_miss: hit=%b data=%h want 0/ab", fwd_hit[1], fwd_data[DW +: DW]);
      end
      checks++; if (fwd_hit[0] !== 1'b1 || fwd_data[DW-1:0] !== 32'h7) begin
         errors++; $display("FAIL mp_hit: hit=%b data=%h want 1/7", fwd_hit[0], fwd_data[DW-1:0]);
      end
   endtask

   task automatic test_random();
      ent_t e;
      logic eh, ep;
      logic [DW-1:0] ed;
      drain();
      for (int n = 0; n < 400; n++) begin
         stall   = ($urandom_range(0, 4) == 0);
         flush   = ($urandom_range(0, 7) == 0);
         e_we    = ($urandom_range(0, 3) != 0);
         e_late  = ($urandom_range(0, 2) == 0);
         e_addr  = AW'($urandom_range(0, 7));
         e_data  = $urandom();
         ld_data = $urandom();
         rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         rf_rdata = {$urandom(), $urandom()};
         #1;
         for (int k = 0; k < NRD; k++) begin
            eh = 1'b0; ep = 1'b0; ed = rf_rdata[k*DW +: DW];
            for (int s = 0; s <= DEPTH && !eh; s++) begin
               e = model_stage(s);
               if (e.v && rd_addr[k*AW +: AW] != 0 && e.a == rd_addr[k*AW +: AW]) begin
                  eh = 1'b1; ep = !e.r; ed = e.d;
               end
            end
            checks++; if (fwd_hit[k] !== eh || fwd_pending[k] !== ep) begin
               errors++; $display("FAIL rand_hit[%0d] n=%0d: hit=%b pend=%b want %b/%b", k, n, fwd_hit[k], fwd_pending[k], eh, ep);
            end
            if (!ep) begin
               checks++; if (fwd_data[k*DW +: DW] !== ed) begin
                  errors++; $display("FAIL rand_data[%0d] n=%0d: data=%h want %h", k, n, fwd_data[k*DW +: DW], ed);
               end
            end
         end
         e = model_stage(DEPTH);
         checks++; if (wb_we !== e.v) begin
            errors++; $display("FAIL rand_wbwe n=%0d: we=%b want %b", n, wb_we, e.v);
         end
         if (e.v) begin
            checks++; if (wb_addr !== e.a || wb_data !== e.d) begin
               errors++; $display("FAIL rand_wb n=%0d: addr=%0d data=%h want %0d/%h", n, wb_addr, wb_data, e.a, e.d);
            end
         end
         cycle();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_back_to_back();
      test_load_use();
      test_flush();
      test_zero_and_stall();
      test_multiport();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
